// File: rtl/vec_alu_sched_pkg.sv
// vec_pkg: opcode, op_type and vsew encodings plus the FSM state type
// shared by the vector ALU scheduler and its issue queue.
package vec_pkg;

  localparam logic [5:0] VADD = 6'b000000;
  localparam logic [5:0] VAND = 6'b001001;
  localparam logic [5:0] VOR  = 6'b001010;
  localparam logic [5:0] VXOR = 6'b001011;

  localparam logic [2:0] VV = 3'b001;
  localparam logic [2:0] VX = 3'b010;
  localparam logic [2:0] VI = 3'b100;

  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
  localparam logic [2:0] SEW64 = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  function automatic logic op_legal(
    input logic [5:0] op,
    input logic [2:0] sew,
    input logic [2:0] ty
  );
    logic op_ok;
    logic ty_ok;
    op_ok = (op == VADD) || (op == VAND) ||
            (op == VOR)  || (op == VXOR);
    ty_ok = (ty == VV) || (ty == VX) || (ty == VI);
    return op_ok && (sew <= SEW64) && ty_ok;
  endfunction

endpackage

// File: rtl/vec_alu_sched_if.sv
// vec_alu_sched_if: issue, lane and result bundles of the scheduler.
// slave = scheduler side, master = environment (issuer, lanes, consumer).
interface vec_alu_sched_if #(
  parameter int VLEN = 128,
  parameter int NL   = 4
);
  logic            issue_valid;
  logic            issue_ready;
  logic [5:0]      issue_opcode;
  logic [2:0]      issue_vsew;
  logic [2:0]      issue_op_type;
  logic [VLEN-1:0] issue_vs1;
  logic [VLEN-1:0] issue_vs2;
  logic [4:0]      issue_vd_addr;

  logic            lane_run;
  logic [5:0]      lane_opcode;
  logic [2:0]      lane_vsew;
  logic [2:0]      lane_op_type;
  logic [1:0]      lane_nb_lanes;
  logic [VLEN-1:0] lane_vs1;
  logic [VLEN-1:0] lane_vs2;
  logic [NL-1:0]   lane_done;
  logic [NL*VLEN-1:0] lane_vd;

  logic            res_valid;
  logic            res_ready;
  logic [VLEN-1:0] res_vd;
  logic [4:0]      res_vd_addr;
  logic            res_error;

  modport slave (
    input  issue_valid, issue_opcode, issue_vsew,
    input  issue_op_type, issue_vs1, issue_vs2,
    input  issue_vd_addr,
    output issue_ready,
    output lane_run, lane_opcode, lane_vsew,
    output lane_op_type, lane_nb_lanes,
    output lane_vs1, lane_vs2,
    input  lane_done, lane_vd,
    output res_valid, res_vd, res_vd_addr, res_error,
    input  res_ready
  );

  modport master (
    output issue_valid, issue_opcode, issue_vsew,
    output issue_op_type, issue_vs1, issue_vs2,
    output issue_vd_addr,
    input  issue_ready,
    input  lane_run, lane_opcode, lane_vsew,
    input  lane_op_type, lane_nb_lanes,
    input  lane_vs1, lane_vs2,
    output lane_done, lane_vd,
    input  res_valid, res_vd, res_vd_addr, res_error,
    output res_ready
  );

endinterface

// File: rtl/vec_issue_fifo.sv
// vec_issue_fifo: small circular issue queue with full/empty flags.
// No bypass: a pushed word is visible at dout the cycle after push.
module vec_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full blocks a push even when a pop happens the same cycle
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vec_alu_sched.sv
// vec_alu_sched: queues vector ALU ops, runs them on NL lanes, merges results.
// Define VEC_SCHED_TIMEOUT_EN to add the RUN-state watchdog.
module vec_alu_sched
  import vec_pkg::*;
#(
  parameter int VLEN           = 128,
  parameter int NB_LANES_LOG2  = 2,
  parameter int QDEPTH         = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         reset,
  vec_alu_sched_if.slave io
);

  localparam int NL = 1 << NB_LANES_LOG2;
  localparam int EW = 20 + 2 * VLEN;

  logic [EW-1:0]   push_word;
  logic [EW-1:0]   head;
  logic            full;
  logic            empty;
  logic            pop;

  logic [5:0]      h_op;
  logic [2:0]      h_sew;
  logic [2:0]      h_ty;
  logic [4:0]      h_addr;
  logic [VLEN-1:0] h_vs1;
  logic [VLEN-1:0] h_vs2;
  logic            h_legal;

  state_t          state;
  logic            run_q;
  logic [5:0]      op_q;
  logic [2:0]      sew_q;
  logic [2:0]      ty_q;
  logic [VLEN-1:0] vs1_q;
  logic [VLEN-1:0] vs2_q;
  logic [4:0]      addr_q;
  logic            rv_q;
  logic [VLEN-1:0] vd_q;
  logic [4:0]      rva_q;
  logic            err_q;

  logic [VLEN-1:0] merged;
  logic            all_done;
  logic            tmo_hit;

  assign push_word = {io.issue_opcode, io.issue_vsew,
                      io.issue_op_type, io.issue_vd_addr,
                      io.issue_vs1, io.issue_vs2};
  assign {h_op, h_sew, h_ty, h_addr, h_vs1, h_vs2} = head;
  assign h_legal = op_legal(h_op, h_sew, h_ty);
  assign pop = (state == IDLE) && !empty;

  vec_issue_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (io.issue_valid),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // lanes own disjoint elements, so OR is a lossless merge
  always_comb begin
    merged = '0;
    for (int i = 0; i < NL; i++)
      merged = merged | io.lane_vd[i*VLEN +: VLEN];
  end

  assign all_done = &io.lane_done;

`ifdef VEC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (pop)
      tmo_cnt <= '0;
    else if (state == RUN)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      run_q  <= 1'b0;
      op_q   <= '0;
      sew_q  <= '0;
      ty_q   <= '0;
      vs1_q  <= '0;
      vs2_q  <= '0;
      addr_q <= '0;
      rv_q   <= 1'b0;
      vd_q   <= '0;
      rva_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty && h_legal) begin
            op_q   <= h_op;
            sew_q  <= h_sew;
            ty_q   <= h_ty;
            vs1_q  <= h_vs1;
            vs2_q  <= h_vs2;
            addr_q <= h_addr;
            run_q  <= 1'b1;
            state  <= RUN;
          end else if (!empty) begin
            vd_q  <= '0;
            rva_q <= h_addr;
            err_q <= 1'b1;
            rv_q  <= 1'b1;
            state <= RESP;
          end
        end
        RUN: begin
          if (all_done) begin
            vd_q  <= merged;
            rva_q <= addr_q;
            err_q <= 1'b0;
            rv_q  <= 1'b1;
            run_q <= 1'b0;
            state <= RESP;
          end else if (tmo_hit) begin
            vd_q  <= '0;
            rva_q <= addr_q;
            err_q <= 1'b1;
            rv_q  <= 1'b1;
            run_q <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          if (io.res_ready) begin
            rv_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.issue_ready   = !full;
  assign io.lane_run      = run_q;
  assign io.lane_opcode   = op_q;
  assign io.lane_vsew     = sew_q;
  assign io.lane_op_type  = ty_q;
  assign io.lane_nb_lanes = 2'(NB_LANES_LOG2);
  assign io.lane_vs1      = vs1_q;
  assign io.lane_vs2      = vs2_q;
  assign io.res_valid     = rv_q;
  assign io.res_vd        = vd_q;
  assign io.res_vd_addr   = rva_q;
  assign io.res_error     = err_q;

endmodule

// File: tb/tb_vec_alu_sched.sv
// tb_vec_alu_sched: random and directed ops against an element-level model.
// Lanes are modelled as owning every NL-th element with a tunable latency.
module tb_vec_alu_sched;

  localparam int VL = 128;
  localparam int NL = 4;
  localparam int TO = 255;

  typedef struct {
    logic [VL-1:0] vd;
    logic [4:0]    addr;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lane_lat = 4;
  logic [NL-1:0] lane_stuck = '0;
  int   run_cyc = 0;
  int   rr_mode = 0;
  int   rises = 0;
  logic run_prev = 1'b0;
  int   push_cyc = 0;
  exp_t sb[$];

  vec_alu_sched_if #(.VLEN(VL), .NL(NL)) bus ();

  vec_alu_sched #(
    .VLEN           (VL),
    .NB_LANES_LOG2  (2),
    .QDEPTH         (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [VL-1:0] obs,
                     input logic [VL-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VL-1:0] alu(input logic [5:0] op,
                                        input logic [2:0] sew,
                                        input logic [VL-1:0] a,
                                        input logic [VL-1:0] b);
    int ew;
    logic [VL-1:0] m, x, y, r;
    ew = 8 << sew;
    m  = (VL'(1) << ew) - 1;
    r  = '0;
    for (int j = 0; j < VL / ew; j++) begin
      x = (a >> (j * ew)) & m;
      y = (b >> (j * ew)) & m;
      case (op)
        6'b000000: r = r | (((x + y) & m) << (j * ew));
        6'b001001: r = r | ((x & y) << (j * ew));
        6'b001010: r = r | ((x | y) << (j * ew));
        6'b001011: r = r | ((x ^ y) << (j * ew));
        default:   r = r;
      endcase
    end
    return r;
  endfunction

  function automatic logic [VL-1:0] lmask(input int ln,
                                          input logic [2:0] sew);
    int ew;
    logic [VL-1:0] m, r;
    ew = 8 << sew;
    m  = (VL'(1) << ew) - 1;
    r  = '0;
    for (int j = ln; j < VL / ew; j += NL)
      r = r | (m << (j * ew));
    return r;
  endfunction

  function automatic logic [NL*VL-1:0] lanes_vd(input logic [5:0] op,
                                                input logic [2:0] sew,
                                                input logic [VL-1:0] a,
                                                input logic [VL-1:0] b);
    logic [NL*VL-1:0] v;
    logic [VL-1:0] f;
    v = '0;
    f = alu(op, sew, a, b);
    for (int i = 0; i < NL; i++)
      v[i*VL +: VL] = f & lmask(i, sew);
    return v;
  endfunction

  function automatic logic legal(input logic [5:0] op,
                                 input logic [2:0] sew,
                                 input logic [2:0] ty);
    return (op inside {6'h00, 6'h09, 6'h0a, 6'h0b}) &&
           (sew < 3'd4) && (ty inside {3'b001, 3'b010, 3'b100});
  endfunction

  // lane model: result driven from the broadcast operands, done after lane_lat
  assign bus.lane_vd = lanes_vd(bus.lane_opcode, bus.lane_vsew,
                                bus.lane_vs1, bus.lane_vs2);
  assign bus.lane_done = (bus.lane_run && run_cyc >= lane_lat) ?
                         ~lane_stuck : '0;

  always @(posedge clk) run_cyc <= bus.lane_run ? run_cyc + 1 : 0;

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.lane_run && !run_prev) rises++;
    run_prev = bus.lane_run;
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", bus.res_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_vd", bus.res_vd, e.vd);
        chk("res_addr", VL'(bus.res_vd_addr), VL'(e.addr));
        chk("res_err", VL'(bus.res_error), VL'(e.err));
      end
    end
  end

  task automatic push(input logic [5:0] op, input logic [2:0] sew,
                      input logic [2:0] ty, input logic [VL-1:0] a,
                      input logic [VL-1:0] b, input logic [4:0] addr,
                      input logic tmo);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!bus.issue_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!bus.issue_ready) begin
      chk("push_wait", VL'(bus.issue_ready), VL'(1));
      return;
    end
    bus.issue_opcode  = op;
    bus.issue_vsew    = sew;
    bus.issue_op_type = ty;
    bus.issue_vs1     = a;
    bus.issue_vs2     = b;
    bus.issue_vd_addr = addr;
    bus.issue_valid   = 1'b1;
    @(posedge clk);
    #1;
    push_cyc = cyc;
    bus.issue_valid = 1'b0;
    e.addr = addr;
    if (legal(op, sew, ty) && !tmo) begin
      e.vd  = alu(op, sew, a, b);
      e.err = 1'b0;
    end else begin
      e.vd  = '0;
      e.err = 1'b1;
    end
    sb.push_back(e);
  endtask

  function automatic logic [VL-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rpush();
    logic [5:0] op;
    logic [2:0] sew, ty;
    int k;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0:       op = 6'h00;
      1:       op = 6'h09;
      2:       op = 6'h0a;
      default: op = 6'h0b;
    endcase
    if (k == 0) op = 6'($urandom_range(0, 63));
    sew = (k == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
    case ($urandom_range(0, 2))
      0:       ty = 3'b001;
      1:       ty = 3'b010;
      default: ty = 3'b100;
    endcase
    if (k == 2) ty = 3'($urandom_range(0, 7));
    push(op, sew, ty, rnd(), rnd(), 5'($urandom), 1'b0);
  endtask

  task automatic wait_valid(input int bound);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.res_valid && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("wait_valid", VL'(bus.res_valid), VL'(1));
  endtask

  task automatic wait_run(input int bound);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.lane_run && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("wait_run", VL'(bus.lane_run), VL'(1));
  endtask

  task automatic drain(input int bound);
    int w;
    w = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.res_valid) && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("drain", VL'(sb.size()), VL'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, t0;
    bus.issue_valid   = 1'b0;
    bus.issue_opcode  = '0;
    bus.issue_vsew    = '0;
    bus.issue_op_type = '0;
    bus.issue_vs1     = '0;
    bus.issue_vs2     = '0;
    bus.issue_vd_addr = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", VL'(bus.issue_ready), VL'(1));
    chk("rst_run", VL'(bus.lane_run), VL'(0));
    chk("rst_valid", VL'(bus.res_valid), VL'(0));
    chk("rst_err", VL'(bus.res_error), VL'(0));
    chk("rst_vd", bus.res_vd, '0);
    chk("rst_addr", VL'(bus.res_vd_addr), VL'(0));
    chk("rst_lane_op", VL'(bus.lane_opcode), VL'(0));
    chk("rst_lane_vs1", bus.lane_vs1, '0);
    chk("nb_lanes", VL'(bus.lane_nb_lanes), VL'(2));
    rst = 1'b0;

    rr_mode  = 0;
    lane_lat = 4;
    push(6'h00, 3'd0, 3'b001, {16{8'h01}}, {16{8'h01}}, 5'd5, 1'b0);
    t0 = push_cyc;
    wait_valid(40);
    chk("lat_023", VL'(cyc - t0), VL'(6));
    chk("vd_023", bus.res_vd, {16{8'h02}});
    drain(40);

    r0 = rises;
    push(6'b111111, 3'd0, 3'b001, rnd(), rnd(), 5'd7, 1'b0);
    wait_valid(40);
    chk("ill_err", VL'(bus.res_error), VL'(1));
    chk("ill_vd", bus.res_vd, '0);
    push(6'h00, 3'd4, 3'b001, rnd(), rnd(), 5'd8, 1'b0);
    push(6'h09, 3'd1, 3'b011, rnd(), rnd(), 5'd9, 1'b0);
    drain(60);
    chk("ill_norun", VL'(rises - r0), VL'(0));

    rr_mode = 2;
    lane_lat = 2;
    push(6'h0b, 3'd2, 3'b010, {4{32'hdeadbeef}}, {4{32'h0f0f0f0f}}, 5'd3, 1'b0);
    push(6'h00, 3'd3, 3'b100, rnd(), rnd(), 5'd4, 1'b0);
    wait_valid(40);
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", VL'(bus.res_valid), VL'(1));
      chk("hold_vd", bus.res_vd, {4{32'hd1a2b1e0}});
      chk("hold_addr", VL'(bus.res_vd_addr), VL'(3));
      chk("hold_run", VL'(bus.lane_run), VL'(0));
    end
    rr_mode = 0;
    drain(60);

    lane_lat = 8;
    r0 = rises;
    push(6'h00, 3'd1, 3'b001, rnd(), rnd(), 5'd10, 1'b0);
    wait_run(20);
    push(6'h09, 3'd0, 3'b001, rnd(), rnd(), 5'd11, 1'b0);
    push(6'h0a, 3'd2, 3'b010, rnd(), rnd(), 5'd12, 1'b0);
    @(negedge clk);
    chk("full_stall", VL'(bus.issue_ready), VL'(0));
    push(6'h0b, 3'd3, 3'b100, rnd(), rnd(), 5'd13, 1'b0);
    drain(200);
    chk("order_runs", VL'(rises - r0), VL'(4));

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      lane_lat = $urandom_range(0, 5);
      rpush();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rr_mode = 0;
    drain(400);

`ifdef VEC_SCHED_TIMEOUT_EN
    lane_lat   = 2;
    lane_stuck = 4'b0001;
    push(6'h00, 3'd0, 3'b001, rnd(), rnd(), 5'd20, 1'b1);
    push(6'h0a, 3'd1, 3'b001, rnd(), rnd(), 5'd21, 1'b0);
    wait_run(20);
    t0 = cyc;
    wait_valid(400);
    chk("tmo_len", VL'(cyc - t0), VL'(TO));
    chk("tmo_err", VL'(bus.res_error), VL'(1));
    lane_stuck = '0;
    drain(100);
`endif

    lane_lat = 30;
    push(6'h00, 3'd2, 3'b001, rnd(), rnd(), 5'd1, 1'b0);
    wait_run(20);
    push(6'h09, 3'd0, 3'b001, rnd(), rnd(), 5'd2, 1'b0);
    push(6'h0a, 3'd0, 3'b001, rnd(), rnd(), 5'd3, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_run", VL'(bus.lane_run), VL'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", VL'(bus.issue_ready), VL'(1));
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_valid", VL'(bus.res_valid), VL'(0));
    end
    chk("post_rst_run", VL'(bus.lane_run), VL'(0));

    lane_lat = 1;
    push(6'h0b, 3'd3, 3'b001, rnd(), rnd(), 5'd31, 1'b0);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
